// File: rtl/sq_dac_pkg.sv
// rtl/sq_dac_pkg.sv - shared widths, state encoding and helpers for the serial DAC transmitter
package sq_dac_pkg;

  localparam int FRAME_W = 16;
  localparam int MANT_W  = 10;
  localparam int EXP_W   = 3;
  localparam int LIN_W   = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } dac_state_t;

  // A 13-bit value fits a signed 10-bit mantissa when its top four bits are all sign copies.
  function automatic logic fits_mant(input logic [LIN_W-1:0] v);
    return (v[LIN_W-1:MANT_W-1] == '0) || (v[LIN_W-1:MANT_W-1] == '1);
  endfunction

endpackage

// File: rtl/sq_lin2float.sv
// rtl/sq_lin2float.sv - combinational linear sample to {exponent, mantissa} converter
module sq_lin2float
  import sq_dac_pkg::*;
(
  input  logic signed [LIN_W-1:0] linear,
  output logic        [EXP_W-1:0] exponent,
  output logic        [MANT_W-1:0] mant
);

  logic signed [LIN_W-1:0] sh1;
  logic signed [LIN_W-1:0] sh2;
  logic signed [LIN_W-1:0] sh3;

  assign sh1 = linear >>> 1;
  assign sh2 = linear >>> 2;
  assign sh3 = linear >>> 3;

  // Pick the smallest arithmetic shift that brings the sample into mantissa range; shift 3 always fits.
  always_comb begin
    exponent = 3'd3;
    mant     = sh3[MANT_W-1:0];
    if (fits_mant(linear)) begin
      exponent = 3'd0;
      mant     = linear[MANT_W-1:0];
    end else if (fits_mant(sh1)) begin
      exponent = 3'd1;
      mant     = sh1[MANT_W-1:0];
    end else if (fits_mant(sh2)) begin
      exponent = 3'd2;
      mant     = sh2[MANT_W-1:0];
    end
  end

endmodule

// File: rtl/sq_dac_tx.sv
// rtl/sq_dac_tx.sv - accepts linear samples and shifts compact float frames out to a serial DAC
module sq_dac_tx
  import sq_dac_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic signed [LIN_W-1:0] linear,
  input  logic                    valid,
  output logic                    ready,
  output logic                    sd,
  output logic                    sck,
  output logic                    ws
);

  localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

  dac_state_t              state;
  logic signed [LIN_W-1:0] sample;
  logic [FRAME_W-1:0]      frame;
  logic [FRAME_W-1:0]      conv;
  logic [EXP_W-1:0]        exponent;
  logic [MANT_W-1:0]       mant;
  logic [7:0]              divcnt;
  logic [3:0]              bitcnt;
  logic [3:0]              bitnext;

  sq_lin2float u_lin2float (
    .linear   (sample),
    .exponent (exponent),
    .mant     (mant)
  );

  assign conv    = {3'b000, exponent, mant};
  assign bitnext = bitcnt - 4'd1;

  // Handshake, frame load and bit shifting; each bit is CLKDIV clocks of sck low then CLKDIV high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      ready  <= 1'b1;
      sd     <= 1'b0;
      sck    <= 1'b0;
      ws     <= 1'b0;
      divcnt <= 8'd0;
      bitcnt <= 4'd0;
      sample <= '0;
      frame  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            sample <= linear;
            ready  <= 1'b0;
            state  <= LOAD;
          end
        end
        LOAD: begin
          frame  <= conv;
          bitcnt <= 4'd15;
          divcnt <= 8'd0;
          sd     <= conv[FRAME_W-1];
          sck    <= 1'b0;
          ws     <= 1'b0;
          state  <= SHIFT;
        end
        SHIFT: begin
          if (divcnt == DIV_LAST) begin
            divcnt <= 8'd0;
            if (!sck) begin
              sck <= 1'b1;
            end else begin
              sck <= 1'b0;
              if (bitcnt == 4'd0) begin
                sd    <= 1'b0;
                ws    <= 1'b0;
                ready <= 1'b1;
                state <= IDLE;
              end else begin
                bitcnt <= bitnext;
                sd     <= frame[bitnext];
                ws     <= (bitnext == 4'd0);
              end
            end
          end else begin
            divcnt <= divcnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sq_dac_tx.sv
// tb/tb_sq_dac_tx.sv - directed self-checking bench for sq_dac_tx at CLKDIV 2 and 1
module tb_sq_dac_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] lin;
  logic        v;
  logic        sel;
  logic        valid2, valid1;
  logic        ready2, sd2, sck2, ws2;
  logic        ready1, sd1, sck1, ws1;
  logic        m_ready, m_sd, m_sck, m_ws;

  int checks = 0;
  int fails  = 0;

  logic [12:0] vin  [7] = '{13'd100, 13'h1FFF, 13'd511, 13'd512, 13'd600, 13'd4095, 13'h1000};
  logic [15:0] vexp [7] = '{16'h0064, 16'h03FF, 16'h01FF, 16'h0500, 16'h052C, 16'h0DFF, 16'h0E00};

  assign valid2  = v & ~sel;
  assign valid1  = v & sel;
  assign m_ready = sel ? ready1 : ready2;
  assign m_sd    = sel ? sd1 : sd2;
  assign m_sck   = sel ? sck1 : sck2;
  assign m_ws    = sel ? ws1 : ws2;

  always #5 clk = ~clk;

  sq_dac_tx #(.CLKDIV(2)) dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .linear  (lin),
    .valid   (valid2),
    .ready   (ready2),
    .sd      (sd2),
    .sck     (sck2),
    .ws      (ws2)
  );

  sq_dac_tx #(.CLKDIV(1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .linear  (lin),
    .valid   (valid1),
    .ready   (ready1),
    .sd      (sd1),
    .sck     (sck1),
    .ws      (ws1)
  );

  task automatic send_frame(input logic [12:0] s, output logic [15:0] f, output int rises,
                            output int ws_bad, output int rdy_low, output bit timeout);
    int   guard;
    logic prev;
    f = '0; rises = 0; ws_bad = 0; rdy_low = 0; timeout = 0;
    guard = 0;
    while (!m_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) timeout = 1;
    lin = s;
    v   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v   = 1'b0;
    lin = 13'h1555;
    prev  = 1'b0;
    guard = 0;
    while (!m_ready && guard < 200) begin
      rdy_low++;
      if (m_sck && !prev) begin
        f = {f[14:0], m_sd};
        rises++;
      end
      if (m_ws !== ((rises == 15 && !m_sck) || (rises == 16 && m_sck))) ws_bad++;
      prev = m_sck;
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) timeout = 1;
  endtask

  task automatic check_frame(input string name, input logic [12:0] s, input logic [15:0] exp_f,
                             input int exp_low);
    logic [15:0] f;
    int rises, ws_bad, rdy_low;
    bit timeout;
    send_frame(s, f, rises, ws_bad, rdy_low, timeout);
    checks++;
    if (timeout) begin fails++; $display("FAIL %s timeout: ready never returned", name); end
    checks++;
    if (f !== exp_f) begin fails++; $display("FAIL %s frame: got %h expected %h", name, f, exp_f); end
    checks++;
    if (rises !== 16) begin fails++; $display("FAIL %s sck rises: got %0d expected 16", name, rises); end
    checks++;
    if (ws_bad !== 0) begin fails++; $display("FAIL %s ws placement: %0d bad cycles expected 0", name, ws_bad); end
    checks++;
    if (rdy_low !== exp_low) begin fails++; $display("FAIL %s ready low: got %0d expected %0d", name, rdy_low, exp_low); end
    checks++;
    if ({m_sd, m_sck, m_ws, m_ready} !== 4'b0001) begin
      fails++;
      $display("FAIL %s end state sd/sck/ws/ready: got %b expected 0001", name, {m_sd, m_sck, m_ws, m_ready});
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; v = 1'b0; sel = 1'b0; lin = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sd2, sck2, ws2, ready2, sd1, sck1, ws1, ready1} !== 8'b0001_0001) begin
      fails++;
      $display("FAIL reset outputs: got %b expected 00010001", {sd2, sck2, ws2, ready2, sd1, sck1, ws1, ready1});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({sd2, sck2, ws2, ready2} !== 4'b0001) begin
      fails++;
      $display("FAIL idle after reset: got %b expected 0001", {sd2, sck2, ws2, ready2});
    end
  endtask

  task automatic test_convert();
    sel = 1'b0;
    for (int i = 0; i < 7; i++) check_frame($sformatf("conv%0d", i), vin[i], vexp[i], 65);
  endtask

  task automatic test_back_to_back();
    logic [12:0] samp [3] = '{13'd1, 13'd2, 13'd3};
    logic [15:0] frames [3];
    logic [15:0] cur;
    int idx, nf, nb, cyc, last_rise, gap_bad, gap_n;
    logic prev;
    sel = 1'b0; idx = 0; nf = 0; nb = 0; cur = '0; last_rise = -1; gap_bad = 0; gap_n = 0;
    prev = 1'b0;
    for (int k = 0; k < 3; k++) frames[k] = '0;
    for (cyc = 0; cyc < 400; cyc++) begin
      if (m_sck && !prev) begin
        if (nb == 0 && last_rise >= 0) begin
          gap_n++;
          if (cyc - last_rise != 6) begin
            gap_bad++;
            $display("FAIL b2b gap: got %0d cycles between frames expected 6", cyc - last_rise);
          end
        end
        cur = {cur[14:0], m_sd};
        nb++;
        last_rise = cyc;
        if (nb == 16) begin
          if (nf < 3) frames[nf] = cur;
          nf++;
          nb = 0;
        end
      end
      prev = m_sck;
      if (m_ready) begin
        if (idx < 3) begin
          lin = samp[idx];
          v   = 1'b1;
          idx++;
        end else begin
          v = 1'b0;
          if (nf >= 3) break;
        end
      end else begin
        lin = 13'(cyc * 37 + 500);
      end
      @(negedge clk);
    end
    v = 1'b0;
    checks++;
    if (nf !== 3) begin fails++; $display("FAIL b2b frame count: got %0d expected 3", nf); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (frames[k] !== 16'(k + 1)) begin
        fails++;
        $display("FAIL b2b frame%0d: got %h expected %h", k, frames[k], 16'(k + 1));
      end
    end
    checks++;
    if (gap_n !== 2 || gap_bad !== 0) begin
      fails++;
      $display("FAIL b2b gaps: got %0d measured %0d bad expected 2 measured 0 bad", gap_n, gap_bad);
    end
  endtask

  task automatic test_midframe_reset();
    int rises, guard;
    logic prev;
    sel = 1'b0; rises = 0; guard = 0; prev = 1'b0;
    while (!m_ready && guard < 300) begin @(negedge clk); guard++; end
    lin = 13'd100; v = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v = 1'b0;
    while (rises < 9 && guard < 300) begin
      if (m_sck && !prev) rises++;
      prev = m_sck;
      if (rises < 9) begin @(negedge clk); guard++; end
    end
    checks++;
    if (rises !== 9) begin fails++; $display("FAIL midreset reach bit7: got %0d rises expected 9", rises); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({m_sd, m_sck, m_ws, m_ready} !== 4'b0001) begin
      fails++;
      $display("FAIL midreset outputs sd/sck/ws/ready: got %b expected 0001", {m_sd, m_sck, m_ws, m_ready});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_frame("after_reset", 13'd100, 16'h0064, 65);
  endtask

  task automatic test_clkdiv1();
    sel = 1'b1;
    @(negedge clk);
    check_frame("div1_100", 13'd100, 16'h0064, 33);
    check_frame("div1_neg", 13'h1000, 16'h0E00, 33);
    check_frame("div1_600", 13'd600, 16'h052C, 33);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_convert();
    test_back_to_back();
    test_midframe_reset();
    test_clkdiv1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sq_dac_tx.md
Name: sq_dac_tx

Overview:
- Sink end of the operator-slot output: accepts signed 13-bit linear samples (as produced by sq_slot.linear) and transmits them to an external serial DAC.
- Each sample is converted to a compact floating-point word (3-bit exponent, 10-bit signed mantissa) and shifted out MSB first.
- The serial output provides a bit clock and a word strobe.
- Sits between the FM slot/mixer output and the chip-level DAC pins.

Parameters:
- CLKDIV, 2: clk cycles per sck half-period; legal range 1..255; bit period = 2*CLKDIV clk cycles.

Ports:
- clk      in   1   system clock
- reset_n  in   1   asynchronous, active-low reset
- linear   in   13  signed sample, two's complement, range -4096..4095
- valid    in   1   sample on linear is offered
- ready    out  1   block can accept a sample this cycle
- sd       out  1   serial data, MSB first
- sck      out  1   serial bit clock; DAC samples sd on the rising edge
- ws       out  1   word strobe; high for the entire final bit (bit 0) of each frame

Behaviour:
- Reset (async, reset_n=0):
  - ready=1, sd=0, sck=0, ws=0; state=IDLE; all counters=0.
  - Reset mid-frame aborts the frame immediately; no partial resume.
- Handshake:
  - A transfer occurs on a rising clk edge with valid&&ready; linear is captured at that edge.
  - ready=1 only in IDLE, so ready drops the cycle after acceptance.
  - valid while ready=0 is ignored; no sample is captured.
  - linear need not be held after the handshake.
- States:
  - IDLE -> LOAD on handshake.
  - LOAD (1 cycle): register the converted frame; bitcnt=15; divcnt=0.
  - LOAD -> SHIFT unconditionally.
  - SHIFT -> IDLE after bit 0 completes.
- Conversion (combinational on the captured sample):
  - s = smallest value in 0..3 such that linear>>>s fits signed 10-bit (-512..511).
  - mant = (linear>>>s)[9:0], arithmetic shift, truncation toward -inf.
  - exp = s.
  - frame[15:0] = {3'b000, exp[2:0], mant[9:0]}.
- Shift timing:
  - Each bit occupies 2*CLKDIV cycles: sck low for the first CLKDIV cycles, high for the next CLKDIV.
  - sd updates on the clk edge where sck goes low, i.e. at bit start.
  - First bit (frame[15]) is driven from the edge ending LOAD.
  - ws=1 exactly while bit 0 is on sd.
  - Frame length = 32*CLKDIV cycles.
  - On the edge ending bit 0's high phase: sck=0, ws=0, sd=0, state=IDLE, ready=1.
  - Handshake-to-next-handshake minimum = 2 + 32*CLKDIV cycles.
- Counters:
  - divcnt width 8, wraps at CLKDIV-1.
  - bitcnt width 4, counts down 15..0; no wrap past 0.

Decomposition:
- Package sq_dac_pkg:
  - FRAME_W=16, MANT_W=10, EXP_W=3, LIN_W=13.
  - State encoding IDLE/LOAD/SHIFT.
- Sub-module sq_lin2float: purely combinational linear->{exp,mant} converter.
  - Instantiated once.
  - Reused later by the mixer for level metering.

Test Plan:
- linear=100, CLKDIV=2 -> frame 16'h0064; sck 16 rising edges; ws high only during bit 0; ready low for 65 cycles after acceptance.
- Signed and negative values:
  - linear=-1 -> 16'h03FF.
  - linear=511 -> 16'h01FF (exp 0).
  - linear=512 -> 16'h0500 (exp 1, mant 256).
- Scaled values:
  - linear=600 -> 16'h052C.
  - linear=4095 -> 16'h0DFF.
  - linear=-4096 -> 16'h0E00.
- Back-to-back streaming:
  - valid held high with samples 1, 2, 3 -> three frames 16'h0001, 16'h0002, 16'h0003.
  - Exactly 2 cycles between end of bit 0 and next frame's bit 15.
  - Samples changed while ready=0 are not transmitted.
- Reset: assert reset_n=0 mid-frame at bit 7 -> same cycle sd=0, sck=0, ws=0, ready=1; after release, new sample 16'h0064 transmits cleanly from bit 15.
- CLKDIV=1 -> 32-cycle frame; sck toggles every clk; bit ordering and ws placement identical to CLKDIV=2.
